// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and register IDs,
// plus the exception test used by pipeline control.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    S_AOK = 4'h1,
    S_HLT = 4'h2,
    S_ADR = 4'h3,
    S_INS = 4'h4
  } stat_e;

  localparam logic [3:0] RSP   = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  function automatic logic is_exc(input logic [3:0] s);
    return (s == S_ADR) || (s == S_INS) || (s == S_HLT);
  endfunction

endpackage

// File: rtl/regfile.sv
// Fifteen 64-bit program registers (IDs 0-E); ID F reads as zero and is never written.
module regfile
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs [0:14];

  // The M-port write comes last so it wins when both ports name one register.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 15; i++) regs[i] <= '0;
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, operand selection with forwarding,
// register file and the pipeline hazard control.
module decode_stage
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  f_icode,
  input  logic [3:0]  f_ifun,
  input  logic [3:0]  f_stat,
  input  logic [3:0]  f_rA,
  input  logic [3:0]  f_rB,
  input  logic [63:0] f_valC,
  input  logic [63:0] f_valP,
  input  logic [3:0]  E_icode,
  input  logic [3:0]  E_destM,
  input  logic [3:0]  M_icode,
  input  logic        e_cnd,
  input  logic [3:0]  m_stat,
  input  logic [3:0]  W_stat,
  input  logic [3:0]  e_destE,
  input  logic [3:0]  M_destE,
  input  logic [3:0]  M_destM,
  input  logic [3:0]  W_destE,
  input  logic [3:0]  W_destM,
  input  logic [63:0] e_valE,
  input  logic [63:0] m_valM,
  input  logic [63:0] M_valE,
  input  logic [63:0] W_valM,
  input  logic [63:0] W_valE,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_stat,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP,
  output logic [3:0]  d_icode,
  output logic [3:0]  d_ifun,
  output logic [3:0]  d_stat,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  d_destE,
  output logic [3:0]  d_destM,
  output logic [63:0] d_valA,
  output logic [63:0] d_valB,
  output logic [63:0] d_valC,
  output logic        set_cc,
  output logic        F_stall,
  output logic        D_stall,
  output logic        D_bubble,
  output logic        E_bubble,
  output logic        M_bubble,
  output logic        W_stall
);

  logic [63:0] rf_a;
  logic [63:0] rf_b;
  logic        loaduse;
  logic        ret_haz;
  logic        mispred;

  // Reset loads the same bubble as D_bubble and overrides stall.
  always_ff @(posedge clk) begin
    if (reset || (!D_stall && D_bubble)) begin
      D_icode <= I_NOP;
      D_ifun  <= '0;
      D_stat  <= S_AOK;
      D_rA    <= RNONE;
      D_rB    <= RNONE;
      D_valC  <= '0;
      D_valP  <= '0;
    end else if (!D_stall) begin
      D_icode <= f_icode;
      D_ifun  <= f_ifun;
      D_stat  <= f_stat;
      D_rA    <= f_rA;
      D_rB    <= f_rB;
      D_valC  <= f_valC;
      D_valP  <= f_valP;
    end
  end

  regfile u_regfile (
    .clk   (clk),
    .reset (reset),
    .src_a (d_srcA),
    .src_b (d_srcB),
    .val_a (rf_a),
    .val_b (rf_b),
    .dst_e (W_destE),
    .val_e (W_valE),
    .dst_m (W_destM),
    .val_m (W_valM)
  );

  always_comb begin
    d_srcA  = RNONE;
    d_srcB  = RNONE;
    d_destE = RNONE;
    d_destM = RNONE;
    case (D_icode)
      I_RRMOVQ: begin d_srcA = D_rA; d_destE = D_rB; end
      I_IRMOVQ: d_destE = D_rB;
      I_RMMOVQ: begin d_srcA = D_rA; d_srcB = D_rB; end
      I_MRMOVQ: begin d_srcB = D_rB; d_destM = D_rA; end
      I_OPQ:    begin d_srcA = D_rA; d_srcB = D_rB; d_destE = D_rB; end
      I_CALL:   begin d_srcB = RSP; d_destE = RSP; end
      I_RET:    begin d_srcA = RSP; d_srcB = RSP; d_destE = RSP; end
      I_PUSHQ:  begin d_srcA = D_rA; d_srcB = RSP; d_destE = RSP; end
      I_POPQ:   begin d_srcA = RSP; d_srcB = RSP; d_destE = RSP; d_destM = D_rA; end
      default:  ;
    endcase
  end

  // A source of F falls through to the register file, which reads it as zero.
  always_comb begin
    if (D_icode == I_CALL || D_icode == I_JXX)        d_valA = D_valP;
    else if (d_srcA != RNONE && d_srcA == e_destE)    d_valA = e_valE;
    else if (d_srcA != RNONE && d_srcA == M_destM)    d_valA = m_valM;
    else if (d_srcA != RNONE && d_srcA == M_destE)    d_valA = M_valE;
    else if (d_srcA != RNONE && d_srcA == W_destM)    d_valA = W_valM;
    else if (d_srcA != RNONE && d_srcA == W_destE)    d_valA = W_valE;
    else                                              d_valA = rf_a;
  end

  always_comb begin
    if (d_srcB != RNONE && d_srcB == e_destE)         d_valB = e_valE;
    else if (d_srcB != RNONE && d_srcB == M_destM)    d_valB = m_valM;
    else if (d_srcB != RNONE && d_srcB == M_destE)    d_valB = M_valE;
    else if (d_srcB != RNONE && d_srcB == W_destM)    d_valB = W_valM;
    else if (d_srcB != RNONE && d_srcB == W_destE)    d_valB = W_valE;
    else                                              d_valB = rf_b;
  end

  assign d_valC  = D_valC;
  assign d_icode = D_icode;
  assign d_ifun  = D_ifun;
  assign d_stat  = D_stat;

  assign loaduse = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_destM != RNONE)
                   && (E_destM == d_srcA || E_destM == d_srcB);
  assign ret_haz = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
  assign mispred = (E_icode == I_JXX) && !e_cnd;

  assign F_stall  = loaduse || ret_haz;
  assign D_stall  = loaduse;
  assign D_bubble = mispred || (ret_haz && !loaduse);
  assign E_bubble = mispred || loaduse;
  assign M_bubble = is_exc(m_stat) || is_exc(W_stat);
  assign W_stall  = is_exc(W_stat);
  assign set_cc   = (E_icode == I_OPQ) && !is_exc(m_stat) && !is_exc(W_stat);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, writeback, forwarding priority,
// load/use, mispredict, ret, exceptions and reset-over-stall.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  f_icode, f_ifun, f_stat, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic [3:0]  E_icode, E_destM, M_icode;
  logic        e_cnd;
  logic [3:0]  m_stat, W_stat;
  logic [3:0]  e_destE, M_destE, M_destM, W_destE, W_destM;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic [3:0]  D_icode, D_ifun, D_stat, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [3:0]  d_icode, d_ifun, d_stat, d_srcA, d_srcB, d_destE, d_destM;
  logic [63:0] d_valA, d_valB, d_valC;
  logic        set_cc, F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset),
    .f_icode(f_icode), .f_ifun(f_ifun), .f_stat(f_stat), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP),
    .E_icode(E_icode), .E_destM(E_destM), .M_icode(M_icode), .e_cnd(e_cnd),
    .m_stat(m_stat), .W_stat(W_stat),
    .e_destE(e_destE), .M_destE(M_destE), .M_destM(M_destM), .W_destE(W_destE), .W_destM(W_destM),
    .e_valE(e_valE), .m_valM(m_valM), .M_valE(M_valE), .W_valM(W_valM), .W_valE(W_valE),
    .D_icode(D_icode), .D_ifun(D_ifun), .D_stat(D_stat), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .d_icode(d_icode), .d_ifun(d_ifun), .d_stat(d_stat), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_destE(d_destE), .d_destM(d_destM),
    .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC),
    .set_cc(set_cc), .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    e_destE = 4'hF; M_destE = 4'hF; M_destM = 4'hF; W_destE = 4'hF; W_destM = 4'hF;
  endtask

  initial begin
    reset = 1'b1;
    f_icode = 4'h1; f_ifun = 4'h0; f_stat = 4'h1; f_rA = 4'hF; f_rB = 4'hF;
    f_valC = '0; f_valP = '0;
    E_icode = 4'h1; E_destM = 4'hF; M_icode = 4'h1; e_cnd = 1'b1;
    m_stat = 4'h1; W_stat = 4'h1;
    clear_fwd();
    e_valE = '0; m_valM = '0; M_valE = '0; W_valM = '0; W_valE = '0;

    edge_step();
    edge_step();
    reset = 1'b0;
    #1;
    check("rst_D_icode", D_icode, 64'h1);
    check("rst_D_stat", D_stat, 64'h1);
    check("rst_D_rA", D_rA, 64'hF);
    check("rst_D_valP", D_valP, 64'h0);
    check("rst_F_stall", F_stall, 64'h0);
    check("rst_D_bubble", D_bubble, 64'h0);

    // Writeback: both ports name r5, valM wins; D loads OPQ r5,r7
    W_destE = 4'h5; W_destM = 4'h5; W_valE = 64'd10; W_valM = 64'd20;
    f_icode = 4'h6; f_ifun = 4'h2; f_rA = 4'h5; f_rB = 4'h7; f_valC = 64'h55; f_valP = 64'h66;
    edge_step();
    clear_fwd();
    #1;
    check("wb_D_icode", D_icode, 64'h6);
    check("wb_d_ifun", d_ifun, 64'h2);
    check("wb_r5_valM_wins", d_valA, 64'd20);
    check("wb_r7_zero", d_valB, 64'd0);
    check("opq_destE", d_destE, 64'h7);
    check("opq_destM", d_destM, 64'hF);
    check("opq_d_valC", d_valC, 64'h55);

    // Forwarding priority on OPQ r2,r3
    f_rA = 4'h2; f_rB = 4'h3;
    edge_step();
    e_destE = 4'h2; e_valE = 64'd111; M_destE = 4'h2; M_valE = 64'd222;
    #1;
    check("fwd_e_over_M", d_valA, 64'd111);
    e_destE = 4'hF;
    #1;
    check("fwd_M_valE", d_valA, 64'd222);
    M_destM = 4'h2; m_valM = 64'd333;
    #1;
    check("fwd_m_over_M_valE", d_valA, 64'd333);
    W_destE = 4'h3; W_valE = 64'd444;
    #1;
    check("fwd_W_valE_srcB", d_valB, 64'd444);
    clear_fwd();
    #1;
    check("fwd_none_r2", d_valA, 64'd0);

    // Load/use on srcB = 3
    E_icode = 4'h5; E_destM = 4'h3; f_icode = 4'h3;
    #1;
    check("lu_F_stall", F_stall, 64'h1);
    check("lu_D_stall", D_stall, 64'h1);
    check("lu_E_bubble", E_bubble, 64'h1);
    check("lu_D_bubble", D_bubble, 64'h0);
    edge_step();
    check("lu_hold_icode", D_icode, 64'h6);
    check("lu_hold_rA", D_rA, 64'h2);
    E_icode = 4'h1; E_destM = 4'hF;

    // Mispredict
    E_icode = 4'h7; e_cnd = 1'b0;
    #1;
    check("mp_D_bubble", D_bubble, 64'h1);
    check("mp_E_bubble", E_bubble, 64'h1);
    check("mp_F_stall", F_stall, 64'h0);
    edge_step();
    check("mp_next_icode", D_icode, 64'h1);
    check("mp_next_rA", D_rA, 64'hF);
    E_icode = 4'h1; e_cnd = 1'b1;

    // Ret
    f_icode = 4'h9; f_rA = 4'hF; f_rB = 4'hF;
    edge_step();
    check("ret_F_stall", F_stall, 64'h1);
    check("ret_D_bubble", D_bubble, 64'h1);
    check("ret_D_stall", D_stall, 64'h0);
    check("ret_srcA", d_srcA, 64'h4);
    check("ret_srcB", d_srcB, 64'h4);
    check("ret_destE", d_destE, 64'h4);
    f_icode = 4'h8; f_valP = 64'h1234; f_valC = 64'h99;
    edge_step();
    check("ret_bubbles_D", D_icode, 64'h1);

    // Call: valA takes valP
    edge_step();
    check("call_valA_valP", d_valA, 64'h1234);
    check("call_valC", d_valC, 64'h99);
    check("call_destE", d_destE, 64'h4);

    // Exceptions
    E_icode = 4'h6; W_stat = 4'h3;
    #1;
    check("exc_W_stall", W_stall, 64'h1);
    check("exc_M_bubble", M_bubble, 64'h1);
    check("exc_set_cc", set_cc, 64'h0);
    W_stat = 4'h1;
    #1;
    check("ok_set_cc", set_cc, 64'h1);
    check("ok_M_bubble", M_bubble, 64'h0);
    m_stat = 4'h4;
    #1;
    check("m_ins_M_bubble", M_bubble, 64'h1);
    check("m_ins_W_stall", W_stall, 64'h0);
    check("m_ins_set_cc", set_cc, 64'h0);
    m_stat = 4'h1;

    // Reset beats stall and discards a coincident write
    E_icode = 4'h5; E_destM = 4'h4;
    #1;
    check("pre_rst_D_stall", D_stall, 64'h1);
    reset = 1'b1; W_destE = 4'h6; W_valE = 64'd77;
    edge_step();
    reset = 1'b0;
    clear_fwd();
    E_icode = 4'h1; E_destM = 4'hF;
    #1;
    check("rst_over_stall", D_icode, 64'h1);
    f_icode = 4'h6; f_rA = 4'h5; f_rB = 4'h6;
    edge_step();
    check("rst_clears_r5", d_valA, 64'd0);
    check("rst_drops_write_r6", d_valB, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
